textmode_fetch: RTL and testbench

Display-side reader for textmode RAM (TRAM), running in the pixel clock domain. It walks the text grid in step with the display timing, reads one TRAM word per character cell on the display port, and looks up the glyph row in an external font ROM. It then serialises glyph bits into foreground/background colour indices for the pixel pipeline. The output has a fixed 3-cycle latency relative to `de`, so display timing delays its syncs by 3 cycles to match.

---
 rtl/textmode_fetch_pkg.sv | 9 +
 rtl/textmode_fetch.sv | 122 ++++++++++++
 tb/tb_textmode_fetch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/textmode_fetch_pkg.sv
// Shared constants for the textmode display fetch path: TRAM word layout
// and the fixed pixel latency that display timing uses to delay its syncs.
package textmode_fetch_pkg;
  localparam int CHAR_LSB     = 0;
  localparam int FG_LSB       = 8;
  localparam int BG_LSB       = 16;
  localparam int CHARW        = 8;
  localparam int TEXTMODE_LAT = 3;
endpackage

// File: rtl/textmode_fetch.sv
// Display-side TRAM reader: walks the text grid with display timing, fetches
// one word per cell, looks up the glyph row and serialises it into colour indices.
module textmode_fetch
  import textmode_fetch_pkg::*;
#(
  parameter int ADDRW      = 12,
  parameter int WORD       = 32,
  parameter int TEXT_COLS  = 80,
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int CIDXW      = 4,
  parameter int FONT_ADDRW = 12
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  de,
  output logic [ADDRW-1:0]      addr_disp,
  input  logic [WORD-1:0]       dout_disp,
  output logic [FONT_ADDRW-1:0] font_addr,
  input  logic [GLYPH_W-1:0]    font_data,
  output logic [CIDXW-1:0]      pix_colr,
  output logic                  pix_de
);
  localparam int PXW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int PYW = $clog2(GLYPH_H);

  logic [PXW-1:0]   px, px_n;
  logic [ADDRW-1:0] col, col_n, row_base, rb_n;
  logic [PYW-1:0]   py, py_n, py_s1;
  logic             de_q, cell_s0;
  logic [TEXTMODE_LAT:1] de_pipe;
  logic [2:1]       vld_pipe;
  logic [CIDXW-1:0] fg_s1, bg_s1, fg, bg;
  logic [GLYPH_W-1:0] glyph_sr;
  logic             unused_word;

  assign unused_word = ^dout_disp;
  assign cell_s0     = de && (px == '0);

  // Counter next-state; frame/line starts override pixel stepping, even mid-line.
  always_comb begin
    px_n  = px;
    col_n = col;
    py_n  = py;
    rb_n  = row_base;
    if (de) begin
      if (px == PXW'(GLYPH_W - 1)) begin
        px_n  = '0;
        col_n = col + ADDRW'(1);
      end else begin
        px_n = px + PXW'(1);
      end
    end
    if (de_q && !de) begin
      if (py == PYW'(GLYPH_H - 1)) begin
        py_n = '0;
        rb_n = row_base + ADDRW'(TEXT_COLS);
      end else begin
        py_n = py + PYW'(1);
      end
    end
    if (line_start) begin
      col_n = '0;
      px_n  = '0;
    end
    if (frame_start) begin
      rb_n  = '0;
      py_n  = '0;
      col_n = '0;
      px_n  = '0;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      px        <= '0;
      col       <= '0;
      py        <= '0;
      row_base  <= '0;
      addr_disp <= '0;
      de_q      <= 1'b0;
      de_pipe   <= '0;
      vld_pipe  <= '0;
      py_s1     <= '0;
      fg_s1     <= '0;
      bg_s1     <= '0;
      fg        <= '0;
      bg        <= '0;
      glyph_sr  <= '0;
    end else begin
      px        <= px_n;
      col       <= col_n;
      py        <= py_n;
      row_base  <= rb_n;
      // Registered from next-state so the address is on the bus in the cell's first cycle.
      addr_disp <= rb_n + col_n;
      de_q      <= de;
      de_pipe   <= {de_pipe[TEXTMODE_LAT-1:1], de};
      vld_pipe  <= {vld_pipe[1], cell_s0};
      if (cell_s0) py_s1 <= py;
      if (vld_pipe[1]) begin
        fg_s1 <= dout_disp[FG_LSB +: CIDXW];
        bg_s1 <= dout_disp[BG_LSB +: CIDXW];
      end
      // A new cell's load replaces any leftover bits of a partial cell.
      if (vld_pipe[2]) begin
        glyph_sr <= font_data;
        fg       <= fg_s1;
        bg       <= bg_s1;
      end else begin
        glyph_sr <= glyph_sr << 1;
      end
    end
  end

  // Font address comes straight off the TRAM data so the ROM read fits in S1.
  assign font_addr = vld_pipe[1] ? {dout_disp[CHAR_LSB +: CHARW], py_s1} : '0;
  assign pix_de    = de_pipe[TEXTMODE_LAT];
  assign pix_colr  = pix_de ? (glyph_sr[GLYPH_W-1] ? fg : bg) : '0;
endmodule

// File: tb/tb_textmode_fetch.sv
// Directed bench for textmode_fetch: table-driven single cell plus line-level
// sequences for stride, wrap, back-to-back, partial cell and async reset.
module tb_textmode_fetch;
  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic        frame_start, line_start, de;
  logic [11:0] addr_disp;
  logic [31:0] dout_disp;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  pix_colr;
  logic        pix_de;

  logic [3:0]  s_addr;
  logic [31:0] s_dout = '0;
  logic [11:0] s_faddr;
  logic [7:0]  s_fdata = '0;
  logic [3:0]  s_colr;
  logic        s_pde;

  logic [31:0] tram [0:4095];
  logic [7:0]  font [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  textmode_fetch #(.ADDRW(12)) u_dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start),
    .line_start(line_start), .de(de), .addr_disp(addr_disp),
    .dout_disp(dout_disp), .font_addr(font_addr), .font_data(font_data),
    .pix_colr(pix_colr), .pix_de(pix_de));

  textmode_fetch #(.ADDRW(4), .TEXT_COLS(10)) u_small (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start),
    .line_start(line_start), .de(de), .addr_disp(s_addr),
    .dout_disp(s_dout), .font_addr(s_faddr), .font_data(s_fdata),
    .pix_colr(s_colr), .pix_de(s_pde));

  always @(posedge clk_pix) begin
    dout_disp <= tram[addr_disp];
    font_data <= font[font_addr];
  end

  typedef struct {
    logic       f, l, d;
    logic       pde;
    logic [3:0] colr;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic f, input logic l, input logic d);
    @(negedge clk_pix);
    frame_start = f;
    line_start  = l;
    de          = d;
  endtask

  // Drives de for n cycles and checks fetch addresses, font addresses and pixels.
  task automatic run_line(input int n, input int base, input int py, input int base2,
                          input string tag);
    for (int s = 0; s < n + 4; s++) begin
      step(0, 0, s < n);
      if (s < n && s % 8 == 0) begin
        check({tag, " addr"}, int'(addr_disp), (base + s / 8) & 12'hfff);
        if (base2 >= 0) check({tag, " small addr"}, int'(s_addr), (base2 + s / 8) & 4'hf);
      end
      if (s >= 1 && s - 1 < n && (s - 1) % 8 == 0) begin
        logic [31:0] w;
        w = tram[(base + (s - 1) / 8) & 12'hfff];
        check({tag, " font_addr"}, int'(font_addr), int'({w[7:0], 4'(py)}));
      end
      if (s >= 3 && s < n + 3) begin
        int p;
        logic [31:0] w;
        logic [7:0]  g;
        p = s - 3;
        w = tram[(base + p / 8) & 12'hfff];
        g = font[{w[7:0], 4'(py)}];
        check({tag, " pix_de"}, int'(pix_de), 1);
        check({tag, " pix_colr"}, int'(pix_colr),
              int'(g[7 - p % 8] ? w[11:8] : w[19:16]));
      end else begin
        check({tag, " pix_de idle"}, int'(pix_de), 0);
        check({tag, " pix_colr idle"}, int'(pix_colr), 0);
      end
    end
  endtask

  vec_t vecs [15];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tram[i] = {8'hA5, 4'h0, 4'(i * 7 + 3), 4'h0, 4'(i * 5 + 1), 8'(i + 8'h40)};
      font[i] = 8'(i * 37 + 11);
    end
    tram[0]     = 32'h0002_0141;
    font[12'h410] = 8'h18;

    // Single cell: fg=1, bg=2, glyph 0x18 -> 2,2,2,1,1,2,2,2 three cycles after de.
    vecs[0]  = '{1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 2};
    vecs[6]  = '{0, 0, 1, 1, 2};
    vecs[7]  = '{0, 0, 1, 1, 2};
    vecs[8]  = '{0, 0, 1, 1, 1};
    vecs[9]  = '{0, 0, 1, 1, 1};
    vecs[10] = '{0, 0, 0, 1, 2};
    vecs[11] = '{0, 0, 0, 1, 2};
    vecs[12] = '{0, 0, 0, 1, 2};
    vecs[13] = '{0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0};

    rst_pix = 1'b1; frame_start = 0; line_start = 0; de = 0;
    repeat (2) @(negedge clk_pix);
    check("reset addr_disp", int'(addr_disp), 0);
    check("reset font_addr", int'(font_addr), 0);
    check("reset pix_colr", int'(pix_colr), 0);
    check("reset pix_de", int'(pix_de), 0);
    rst_pix = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].f, vecs[i].l, vecs[i].d);
      if (i == 2) check("cell0 addr", int'(addr_disp), 0);
      if (i == 3) check("cell0 font_addr", int'(font_addr), 12'h410);
      check($sformatf("vec%0d pix_de", i), int'(pix_de), int'(vecs[i].pde));
      check($sformatf("vec%0d pix_colr", i), int'(pix_colr), int'(vecs[i].colr));
    end

    // frame_start and line_start together, then three back-to-back cells.
    step(1, 1, 0);
    run_line(24, 0, 0, 0, "b2b");

    // Row stride and small-DUT address wrap (10, then 20 mod 16 = 4).
    step(1, 0, 0);
    for (int L = 0; L <= 32; L++) begin
      step(0, 1, 0);
      run_line(8, (L / 16) * 80, L % 16, ((L / 16) * 10) % 16, $sformatf("stride%0d", L));
    end
    step(1, 0, 0);
    step(0, 1, 0);
    run_line(8, 0, 0, 0, "refetch");

    // Partial cell: 12 pixels, then next line restarts at col 0 with py+1.
    step(0, 1, 0);
    run_line(12, 0, 1, 0, "partial");
    step(0, 1, 0);
    run_line(8, 0, 2, 0, "after_partial");

    // Async reset mid-cell.
    step(0, 1, 0);
    for (int s = 0; s < 6; s++) step(0, 0, 1);
    check("pre-reset pix_de", int'(pix_de), 1);
    #2 rst_pix = 1'b1;
    #1;
    check("async pix_de", int'(pix_de), 0);
    check("async pix_colr", int'(pix_colr), 0);
    check("async addr_disp", int'(addr_disp), 0);
    check("async font_addr", int'(font_addr), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    rst_pix = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    run_line(8, 0, 0, 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
